// File: rtl/elevator_motion_ctrl.sv
// elevator_motion_ctrl
// Cabin motion controller running a SCAN (collective) policy. It moves the
// cabin one floor per MOVE_CYCLES clocks, stops where the pending request
// bitmaps ask for a stop, and holds the door open for DOOR_CYCLES clocks.
// The registered Floor output feeds back to the upstream floor-request selector.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   Dest_up    pending up-destination bitmap (bit i = floor i)
//   Dest_down  pending down-destination bitmap
//   arrive     selector flag: stop requested at current Floor
//   Floor      registered current floor
//   dir_up     current/last travel direction, 1 = up
//   moving     1 while travelling up or down
//   door_open  1 while the door is open
//   busy       1 in any state except idle
module elevator_motion_ctrl #(
  parameter int unsigned n           = 20,
  parameter int unsigned MOVE_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] Dest_up,
  input  logic [n-1:0] Dest_down,
  input  logic         arrive,
  output logic [4:0]   Floor,
  output logic         dir_up,
  output logic         moving,
  output logic         door_open,
  output logic         busy
);

  localparam int unsigned MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);
  localparam logic [4:0]    TOP_FLOOR = 5'(n - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [4:0]    floor_nxt;
  logic          dir_nxt;
  logic [MW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] door_cnt, door_cnt_nxt;
  logic          check, check_nxt;   // first cycle at a freshly reached floor

  logic [n-1:0]  pending;
  logic          above, below, here, here_up, here_down;
  logic          stop_up, stop_down;
  logic          going_up;

  // Request summary relative to the current floor.
  always_comb begin
    pending   = Dest_up | Dest_down;
    above     = 1'b0;
    below     = 1'b0;
    here_up   = 1'b0;
    here_down = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      if (i > int'(Floor)) above = above | pending[i];
      if (i < int'(Floor)) below = below | pending[i];
      if (i == int'(Floor)) begin
        here_up   = Dest_up[i];
        here_down = Dest_down[i];
      end
    end
    here = here_up | here_down;
    // Opposite-direction calls are only taken when nothing lies further ahead.
    stop_up   = here_up   | arrive | (here_down & ~above);
    stop_down = here_down | arrive | (here_up   & ~below);
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_nxt    = state;
    floor_nxt    = Floor;
    dir_nxt      = dir_up;
    cnt_nxt      = cnt;
    door_cnt_nxt = door_cnt;
    check_nxt    = 1'b0;
    going_up     = (state == MOVE_UP);
    case (state)
      IDLE: begin
        cnt_nxt      = '0;
        door_cnt_nxt = '0;
        if (arrive || here) begin
          state_nxt = DOOR;
        end else if (dir_up ? above : below) begin
          state_nxt = dir_up ? MOVE_UP : MOVE_DOWN;
        end else if (dir_up ? below : above) begin
          state_nxt = dir_up ? MOVE_DOWN : MOVE_UP;
          dir_nxt   = ~dir_up;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (check && (going_up ? stop_up : stop_down)) begin
          state_nxt    = DOOR;
          cnt_nxt      = '0;
          door_cnt_nxt = '0;
        end else if (check && (going_up ? (Floor == TOP_FLOOR || !above)
                                        : (Floor == 5'd0 || !below))) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == MOVE_LAST) begin
          cnt_nxt = '0;
          // Guard the shaft ends even if the request picture changed mid-move.
          if (going_up ? (Floor == TOP_FLOOR) : (Floor == 5'd0)) begin
            state_nxt = IDLE;
          end else begin
            floor_nxt = going_up ? (Floor + 5'd1) : (Floor - 5'd1);
            check_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + MW'(1);
        end
      end
      DOOR: begin
        if (door_cnt == DOOR_LAST) begin
          door_cnt_nxt = '0;
          cnt_nxt      = '0;
          if (dir_up ? above : below) begin
            state_nxt = dir_up ? MOVE_UP : MOVE_DOWN;
          end else if (dir_up ? below : above) begin
            state_nxt = dir_up ? MOVE_DOWN : MOVE_UP;
            dir_nxt   = ~dir_up;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          door_cnt_nxt = door_cnt + DW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      Floor     <= 5'd0;
      dir_up    <= 1'b1;
      cnt       <= '0;
      door_cnt  <= '0;
      check     <= 1'b0;
      moving    <= 1'b0;
      door_open <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      Floor     <= floor_nxt;
      dir_up    <= dir_nxt;
      cnt       <= cnt_nxt;
      door_cnt  <= door_cnt_nxt;
      check     <= check_nxt;
      moving    <= (state_nxt == MOVE_UP) || (state_nxt == MOVE_DOWN);
      door_open <= (state_nxt == DOOR);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Testbench for elevator_motion_ctrl: scoreboard of expected door stops
// (floor, opening cycle, direction after close) plus direct status checks.
module tb_elevator_motion_ctrl;

  localparam int unsigned N  = 20;
  localparam int unsigned MC = 4;
  localparam int unsigned DC = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] dest_up;
  logic [N-1:0] dest_down;
  logic         arrive;
  logic [4:0]   floor_o;
  logic         dir_up;
  logic         moving;
  logic         door_open;
  logic         busy;

  elevator_motion_ctrl #(.n(N), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .Dest_up   (dest_up),
    .Dest_down (dest_down),
    .arrive    (arrive),
    .Floor     (floor_o),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned floor;
    int unsigned t;
    int unsigned dir;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        prev_door = 1'b0;
  int unsigned door_w = 0;
  int unsigned max_floor = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: advance to the falling edge, then act as monitor and selector.
  task automatic tick();
    @(negedge clk);
    if (32'(floor_o) > max_floor) max_floor = 32'(floor_o);
    if (reset) begin
      prev_door = 1'b0;
      door_w    = 0;
    end else begin
      if (door_open) begin
        door_w++;
        if (!prev_door) begin
          if (sb.size() == 0) begin
            check("door_unexpected", 32'(floor_o), 99);
          end else begin
            cur = sb.pop_front();
            check("door_floor", 32'(floor_o), cur.floor);
            check("door_time", cyc, cur.t);
          end
          dest_up[floor_o]   = 1'b0;
          dest_down[floor_o] = 1'b0;
        end
      end else if (prev_door) begin
        check("door_width", door_w, DC);
        check("dir_after_door", 32'(dir_up), cur.dir);
        door_w = 0;
      end
      prev_door = door_open;
    end
  endtask

  task automatic push_exp(input int unsigned f, input int unsigned t, input int unsigned d);
    exp_t e;
    e.floor = f;
    e.t     = t;
    e.dir   = d;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    tick();
    tick();
    k = 0;
    while ((busy || sb.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    if (busy || sb.size() != 0) check("idle_timeout", 1, 0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    dest_up   = '0;
    dest_down = '0;
    sb.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_floor"}, 32'(floor_o), 0);
    check({tag, "_moving"}, 32'(moving), 0);
    check({tag, "_door"}, 32'(door_open), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_dir"}, 32'(dir_up), 1);
  endtask

  initial begin
    int unsigned c;
    int k;
    reset     = 1'b1;
    dest_up   = '0;
    dest_down = '0;
    arrive    = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("idle_floor", 32'(floor_o), 0);
    check("idle_busy", 32'(busy), 0);

    // Single up request 0 -> 5.
    c = cyc;
    push_exp(5, c + 5 * MC + 2, 1);
    dest_up[5] = 1'b1;
    tick();
    check("start_moving", 32'(moving), 1);
    check("start_floor", 32'(floor_o), 0);
    for (int i = 0; i < int'(MC); i++) tick();
    check("first_step_floor", 32'(floor_o), 1);
    wait_idle(300);
    check("t1_floor", 32'(floor_o), 5);
    check("t1_busy", 32'(busy), 0);

    // From 5 with dir up: down call at 2 and up call at 9 -> 9 first, then 2.
    check("t3_dir_before", 32'(dir_up), 1);
    c = cyc;
    push_exp(9, c + 4 * MC + 2, 0);
    push_exp(2, c + 4 * MC + 2 + DC + 7 * MC + 1, 0);
    dest_down[2] = 1'b1;
    dest_up[9]   = 1'b1;
    wait_idle(300);
    check("t3_floor", 32'(floor_o), 2);

    // Pass the down call at 7 on the way up to 12, then serve 7 on the way back.
    do_reset();
    c = cyc;
    push_exp(12, c + 12 * MC + 2, 0);
    push_exp(7, c + 12 * MC + 2 + DC + 5 * MC + 1, 0);
    dest_down[7] = 1'b1;
    dest_up[12]  = 1'b1;
    wait_idle(400);
    check("t4_floor", 32'(floor_o), 7);

    // Top end, then bottom end.
    do_reset();
    c = cyc;
    push_exp(19, c + 19 * MC + 2, 1);
    dest_up[19] = 1'b1;
    wait_idle(400);
    check("t5_top_floor", 32'(floor_o), 19);
    for (int i = 0; i < 5; i++) tick();
    check("t5_top_idle", 32'(busy), 0);
    c = cyc;
    push_exp(0, c + 19 * MC + 2, 0);
    dest_down[0] = 1'b1;
    wait_idle(400);
    check("t5_bottom_floor", 32'(floor_o), 0);

    // Reset in the middle of a move.
    dest_up[8] = 1'b1;
    k = 0;
    tick();
    while (!(floor_o == 5'd3 && moving) && k < 200) begin
      tick();
      k++;
    end
    check("t6_reached_3", 32'(floor_o), 3);
    check("t6_moving_at_3", 32'(moving), 1);
    reset     = 1'b1;
    dest_up   = '0;
    dest_down = '0;
    tick();
    check_reset_outputs("reset_mid_move");
    tick();
    reset = 1'b0;
    tick();

    // Reset while the door is open.
    c = cyc;
    push_exp(2, c + 2 * MC + 2, 1);
    dest_up[2] = 1'b1;
    k = 0;
    tick();
    while (!door_open && k < 200) begin
      tick();
      k++;
    end
    check("t6_door_seen", 32'(door_open), 1);
    reset     = 1'b1;
    dest_up   = '0;
    dest_down = '0;
    sb.delete();
    tick();
    check_reset_outputs("reset_mid_door");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("post_reset_busy", 32'(busy), 0);

    check("max_floor", max_floor, 19);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
